// File: rtl/io_port_slave.sv
// io_port_slave: chip-side responder for the FPGA test-host port bus.
// Accepts a one-word header. A write streams payload beats straight through
// to the internal sink. A read pulses rd_req for one turnaround cycle, then
// streams source beats straight back to the FPGA. Both directions are
// combinational pass-throughs, so the block adds no data latency.
module io_port_slave #(
  parameter int PORT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // FPGA-facing port bus
  input  logic [PORT_WIDTH-1:0] io_din,
  input  logic                  io_din_vld,
  output logic                  io_din_rdy,
  output logic [PORT_WIDTH-1:0] io_dout,
  output logic                  io_dout_vld,
  input  logic                  io_dout_rdy,
  // internal sink (write payload)
  output logic [PORT_WIDTH-1:0] wr_dat,
  output logic                  wr_vld,
  output logic                  wr_last,
  input  logic                  wr_rdy,
  // internal source (read payload)
  output logic                  rd_req,
  input  logic [PORT_WIDTH-1:0] rd_dat,
  input  logic                  rd_vld,
  output logic                  rd_rdy,
  // transaction status
  output logic [2:0]            tgt,
  output logic [11:0]           len,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a header
    WR   = 2'd1,  // streaming write beats io_din -> wr_*
    TA   = 2'd2,  // one turnaround cycle; rd_req asserted
    RD   = 2'd3   // streaming read beats rd_* -> io_dout
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic [11:0] len_nxt;
  logic [2:0]  tgt_nxt;
  logic        rd_req_nxt;

  // Header fields; only the low 16 bits carry meaning when PORT_WIDTH > 16.
  logic        hdr_rw;
  logic [2:0]  hdr_tgt;
  logic [11:0] hdr_len;

  assign hdr_rw  = io_din[15];
  assign hdr_tgt = io_din[14:12];
  assign hdr_len = io_din[11:0];

  // cnt == len identifies the final beat of either direction.
  logic last_beat;
  assign last_beat = (cnt == len);

  assign busy = (state != IDLE);

  // Next-state, counter/field updates and all pass-through outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    tgt_nxt     = tgt;
    len_nxt     = len;
    rd_req_nxt  = 1'b0;
    io_din_rdy  = 1'b0;
    wr_dat      = '0;
    wr_vld      = 1'b0;
    wr_last     = 1'b0;
    io_dout     = '0;
    io_dout_vld = 1'b0;
    rd_rdy      = 1'b0;

    unique case (state)
      IDLE: begin
        io_din_rdy = 1'b1;
        if (io_din_vld) begin
          tgt_nxt = hdr_tgt;
          len_nxt = hdr_len;
          cnt_nxt = '0;
          if (hdr_rw) begin
            state_nxt = WR;
          end else begin
            // rd_req is registered so it is high for exactly the TA cycle.
            state_nxt  = TA;
            rd_req_nxt = 1'b1;
          end
        end
      end

      WR: begin
        wr_dat     = io_din;
        wr_vld     = io_din_vld;
        io_din_rdy = wr_rdy;
        wr_last    = last_beat;
        if (io_din_vld && wr_rdy) begin
          // Hold cnt on the final beat so a 4096-beat burst never wraps it.
          if (last_beat) state_nxt = IDLE;
          else           cnt_nxt   = cnt + 12'd1;
        end
      end

      TA: begin
        state_nxt = RD;
      end

      RD: begin
        io_dout     = rd_dat;
        io_dout_vld = rd_vld;
        rd_rdy      = io_dout_rdy;
        if (rd_vld && io_dout_rdy) begin
          if (last_beat) state_nxt = IDLE;
          else           cnt_nxt   = cnt + 12'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, beat counter, latched header fields and the rd_req pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tgt    <= '0;
      len    <= '0;
      rd_req <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tgt    <= tgt_nxt;
      len    <= len_nxt;
      rd_req <= rd_req_nxt;
    end
  end

endmodule
